stall_scoreboard: RTL and testbench

STALL_SCOREBOARD -- requirements
Module: stall_scoreboard

---
 rtl/stall_scoreboard_pkg.sv | 14 +
 rtl/stall_scoreboard_sb.sv | 39 +++
 rtl/stall_scoreboard.sv | 124 ++++++++++++
 tb/tb_stall_scoreboard.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/stall_scoreboard_pkg.sv
// Shared constants for the D-stage stall scoreboard: default field widths,
// mult/div latencies and the hardwired zero register.
package stall_scoreboard_pkg;

   localparam int         TW_DEF       = 2;
   localparam int         MULT_LAT_DEF = 5;
   localparam int         DIV_LAT_DEF  = 10;
   localparam logic [4:0] REG_ZERO     = 5'd0;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/stall_scoreboard_sb.sv
// One scoreboard stage register {wa, tnew}; downstream stages age tnew by one
// cycle per advance, saturating at zero.
module sb_entry
   import stall_scoreboard_pkg::*;
#(
   parameter int TW  = TW_DEF,
   parameter bit DEC = 1'b1
)
(
   input  logic          clk,
   input  logic          reset,
   input  logic          i_adv,
   input  logic [4:0]    i_wa,
   input  logic [TW-1:0] i_tnew,
   output logic [4:0]    o_wa,
   output logic [TW-1:0] o_tnew
);

   logic [4:0]    r_wa;
   logic [TW-1:0] r_tnew;

   function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
      return (t == '0) ? '0 : t - TW'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wa   <= REG_ZERO;
         r_tnew <= '0;
      end else if (i_adv) begin
         r_wa   <= i_wa;
         r_tnew <= DEC ? sat_dec(i_tnew) : i_tnew;
      end
   end

   assign o_wa   = r_wa;
   assign o_tnew = r_tnew;

endmodule

// File: rtl/stall_scoreboard.sv
// D-stage hazard detector: tracks in-flight destination registers and the
// mult/div busy window, and freezes D when an operand is not yet available.
module stall_scoreboard
   import stall_scoreboard_pkg::*;
#(
   parameter int NSRC     = 2,
   parameter int NSTAGE   = 3,
   parameter int TW       = TW_DEF,
   parameter int MULT_LAT = MULT_LAT_DEF,
   parameter int DIV_LAT  = DIV_LAT_DEF,
   parameter int CNT_W    = 32
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              hold,
   input  logic              d_valid,
   input  logic [NSRC*5-1:0] d_ra,
   input  logic [NSRC-1:0]   d_ruse,
   input  logic [NSRC*TW-1:0] d_tuse,
   input  logic [4:0]        d_wa,
   input  logic [TW-1:0]     d_tnew,
   input  logic              d_md_use,
   input  logic              d_md_start,
   input  logic              d_md_div,
   output logic              stall,
   output logic              e_flush,
   output logic [NSRC-1:0]   stall_src,
   output logic              md_busy,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int             MDW     = $clog2(max_int(MULT_LAT, DIV_LAT) + 1);
   localparam logic [MDW-1:0] LAT_MUL = MDW'(MULT_LAT);
   localparam logic [MDW-1:0] LAT_DIV = MDW'(DIV_LAT);

   logic [4:0]       w_wa     [NSTAGE];
   logic [TW-1:0]    w_tnew   [NSTAGE];
   logic [4:0]       w_in_wa  [NSTAGE];
   logic [TW-1:0]    w_in_tnew[NSTAGE];
   logic [NSRC-1:0]  w_src;
   logic             w_hit;
   logic [TW-1:0]    w_hit_tnew;
   logic [4:0]       w_ra;
   logic             w_md_busy;
   logic             w_stall;
   logic             w_issue;
   logic [MDW-1:0]   r_md_cnt;
   logic [CNT_W-1:0] r_stall_cnt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == '1) ? c : c + CNT_W'(1);
   endfunction

   // Scan oldest to youngest so the nearest producer overrides older ones.
   always_comb begin
      w_src      = '0;
      w_hit      = 1'b0;
      w_hit_tnew = '0;
      w_ra       = REG_ZERO;
      for (int i = 0; i < NSRC; i++) begin
         w_ra       = d_ra[5*i +: 5];
         w_hit      = 1'b0;
         w_hit_tnew = '0;
         for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (w_wa[k] != REG_ZERO && w_wa[k] == w_ra) begin
               w_hit      = 1'b1;
               w_hit_tnew = w_tnew[k];
            end
         end
         w_src[i] = d_valid && d_ruse[i] && (w_ra != REG_ZERO) && w_hit &&
                    (w_hit_tnew > d_tuse[TW*i +: TW]);
      end
   end

   assign w_md_busy = (r_md_cnt != '0);
   assign w_stall   = reset && ((|w_src) || (d_valid && (d_md_use || d_md_start) && w_md_busy));
   assign w_issue   = d_valid && !w_stall && !hold;

   for (genvar k = 0; k < NSTAGE; k++) begin : g_sb
      if (k == 0) begin : g_head
         assign w_in_wa[k]   = w_issue ? d_wa   : REG_ZERO;
         assign w_in_tnew[k] = w_issue ? d_tnew : '0;
      end else begin : g_tail
         assign w_in_wa[k]   = w_wa[k-1];
         assign w_in_tnew[k] = w_tnew[k-1];
      end
      sb_entry #(.TW(TW), .DEC(k != 0)) u_entry (
         .clk    (clk),
         .reset  (reset),
         .i_adv  (!hold),
         .i_wa   (w_in_wa[k]),
         .i_tnew (w_in_tnew[k]),
         .o_wa   (w_wa[k]),
         .o_tnew (w_tnew[k])
      );
   end

   // The busy window runs on wall-clock time, so it ignores hold.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_md_cnt <= '0;
      end else if (w_issue && d_md_start) begin
         r_md_cnt <= d_md_div ? LAT_DIV : LAT_MUL;
      end else if (w_md_busy) begin
         r_md_cnt <= r_md_cnt - MDW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_stall_cnt <= '0;
      end else if (w_stall && !hold) begin
         r_stall_cnt <= sat_inc(r_stall_cnt);
      end
   end

   assign stall     = w_stall;
   assign e_flush   = w_stall;
   assign stall_src = reset ? w_src : '0;
   assign md_busy   = reset && w_md_busy;
   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_stall_scoreboard.sv
// Directed bench for stall_scoreboard: load-use, branch-use, mult/div busy,
// hold freeze, nearest-producer priority, reset and counter saturation.
module tb_stall_scoreboard;

   logic        clk = 1'b0;
   logic        reset;
   logic        hold;
   logic        d_valid;
   logic [9:0]  d_ra;
   logic [1:0]  d_ruse;
   logic [3:0]  d_tuse;
   logic [4:0]  d_wa;
   logic [1:0]  d_tnew;
   logic        d_md_use;
   logic        d_md_start;
   logic        d_md_div;
   logic        stall;
   logic        e_flush;
   logic [1:0]  stall_src;
   logic        md_busy;
   logic [3:0]  stall_cnt;

   int checks = 0;
   int errors = 0;
   int n;
   int nbusy;

   stall_scoreboard #(.CNT_W(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .hold       (hold),
      .d_valid    (d_valid),
      .d_ra       (d_ra),
      .d_ruse     (d_ruse),
      .d_tuse     (d_tuse),
      .d_wa       (d_wa),
      .d_tnew     (d_tnew),
      .d_md_use   (d_md_use),
      .d_md_start (d_md_start),
      .d_md_div   (d_md_div),
      .stall      (stall),
      .e_flush    (e_flush),
      .stall_src  (stall_src),
      .md_busy    (md_busy),
      .stall_cnt  (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_d(input logic v, input logic [4:0] ra1, input logic [4:0] ra0,
                        input logic [1:0] ruse, input logic [1:0] tu1, input logic [1:0] tu0,
                        input logic [4:0] wa, input logic [1:0] tnew,
                        input logic mdu, input logic mds, input logic mdd);
      d_valid    = v;
      d_ra       = {ra1, ra0};
      d_ruse     = ruse;
      d_tuse     = {tu1, tu0};
      d_wa       = wa;
      d_tnew     = tnew;
      d_md_use   = mdu;
      d_md_start = mds;
      d_md_div   = mdd;
   endtask

   task automatic idle();
      set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic drain();
      idle();
      repeat (3) tick();
   endtask

   initial begin
      reset = 1'b0;
      hold  = 1'b0;
      idle();
      repeat (2) tick();
      set_d(1, 0, 1, 2'b01, 0, 0, 3, 1, 1, 0, 0);
      #1;
      chk("rst_stall", stall, 0);
      chk("rst_busy", md_busy, 0);
      chk("rst_cnt", stall_cnt, 0);
      chk("rst_src", stall_src, 0);
      reset = 1'b1;
      idle();
      tick();

      // lw $1 then addu reading $1 at tuse=1
      set_d(1, 0, 0, 2'b00, 0, 0, 1, 2, 0, 0, 0);
      #1 chk("lw_nostall", stall, 0);
      tick();
      set_d(1, 0, 1, 2'b01, 0, 1, 3, 1, 0, 0, 0);
      #1;
      chk("addu_stall", stall, 1);
      chk("addu_src", stall_src, 2'b01);
      chk("addu_flush", e_flush, 1);
      tick();
      chk("addu_go", stall, 0);
      chk("addu_cnt", stall_cnt, 1);
      tick();
      drain();

      // lw $1 then beq reading $1 on operand 1 at tuse=0
      set_d(1, 0, 0, 2'b00, 0, 0, 1, 2, 0, 0, 0);
      tick();
      set_d(1, 1, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("beq_stall1", stall, 1);
      chk("beq_src", stall_src, 2'b10);
      tick();
      chk("beq_stall2", stall, 1);
      tick();
      chk("beq_go", stall, 0);
      chk("beq_cnt", stall_cnt, 3);
      tick();
      drain();

      // same pattern against $0
      set_d(1, 0, 0, 2'b00, 0, 0, 0, 2, 0, 0, 0);
      tick();
      set_d(1, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("r0_stall", stall, 0);
      chk("r0_cnt", stall_cnt, 3);
      tick();
      drain();

      // mult then mfhi
      set_d(1, 0, 0, 2'b00, 0, 0, 0, 0, 1, 1, 0);
      tick();
      set_d(1, 0, 0, 2'b00, 0, 0, 2, 1, 1, 0, 0);
      #1;
      n = 0;
      nbusy = 0;
      while (stall && n < 40) begin
         if (md_busy) nbusy++;
         n++;
         tick();
      end
      chk("mult_stalls", n, 5);
      chk("mult_busy_cycles", nbusy, 5);
      chk("mult_busy_done", md_busy, 0);
      chk("mult_cnt", stall_cnt, 8);
      tick();
      drain();

      // hazard frozen by hold while the busy window keeps counting
      set_d(1, 0, 0, 2'b00, 0, 0, 1, 2, 0, 1, 0);
      tick();
      set_d(1, 0, 1, 2'b01, 0, 1, 3, 1, 0, 0, 0);
      hold = 1'b1;
      #1 chk("hold_pre_stall", stall, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_stall", stall, 1);
      end
      chk("hold_cnt", stall_cnt, 8);
      chk("hold_busy", md_busy, 1);
      hold = 1'b0;
      tick();
      chk("rel_stall", stall, 0);
      chk("rel_cnt", stall_cnt, 9);
      chk("rel_busy", md_busy, 1);
      tick();
      chk("rel_busy_done", md_busy, 0);
      drain();

      // $2 in E with tnew=0, older $2 in M with tnew=1
      set_d(1, 0, 0, 2'b00, 0, 0, 2, 2, 0, 0, 0);
      tick();
      set_d(1, 0, 0, 2'b00, 0, 0, 2, 0, 0, 0, 0);
      tick();
      set_d(1, 2, 0, 2'b10, 0, 0, 4, 1, 0, 0, 0);
      #1;
      chk("near_stall", stall, 0);
      chk("near_src", stall_src, 0);
      tick();
      drain();

      // reset mid-divide and mid-stall
      set_d(1, 0, 0, 2'b00, 0, 0, 0, 0, 1, 1, 1);
      tick();
      set_d(1, 0, 0, 2'b00, 0, 0, 1, 2, 0, 0, 0);
      tick();
      set_d(1, 0, 1, 2'b01, 0, 0, 3, 1, 1, 0, 0);
      #1;
      chk("pre_rst_stall", stall, 1);
      chk("pre_rst_busy", md_busy, 1);
      reset = 1'b0;
      tick();
      chk("mid_rst_busy", md_busy, 0);
      chk("mid_rst_stall", stall, 0);
      chk("mid_rst_cnt", stall_cnt, 0);
      reset = 1'b1;
      #1;
      chk("post_rst_stall", stall, 0);
      chk("post_rst_busy", md_busy, 0);
      tick();
      drain();

      // divide latency and stall counter saturation
      for (int r = 0; r < 2; r++) begin
         set_d(1, 0, 0, 2'b00, 0, 0, 0, 0, 1, 1, 1);
         tick();
         set_d(1, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0);
         #1;
         n = 0;
         while (stall && n < 40) begin
            n++;
            tick();
         end
         chk("div_stalls", n, 10);
         chk("div_cnt", stall_cnt, (r == 0) ? 10 : 15);
         tick();
         idle();
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
